circular_shift_sched: RTL and testbench
=======================================

# circular_shift_sched

Batch scheduler for the 257-point circular shifter in the non-power-of-two NTT datapath. It accepts one command that describes a sequence of rotations and streams vectors through the external combinational shifter. The rotation amount for the k-th vector is `(start + k*stride) mod SIZE`. The shifter is registered on both sides, so its long mux chain sits alone between two flop stages. The block sits between the coefficient buffer read port and the butterfly input permutation.

## Interface
Parameters:
- SIZE, 257: vector length in elements; the modulus for shift amounts.
- WIDTH, 32: element width in bits.
- SHW, 9: shift-amount and count width; 2^SHW ≥ SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid; high only in IDLE.
- cmd_start  input  SHW  shift amount for vector 0.
- cmd_stride  input  SHW  shift increment per vector.
- cmd_count  input  SHW  number of vectors in the batch; 0 is legal.
- in_valid  input  1  input vector offered.
- in_ready  output  1  input vector accepted.
- in_list  input  SIZE*WIDTH  input vector; element i occupies bits [i*WIDTH +: WIDTH].
- sh_list_o  output  SIZE*WIDTH  stage-1 register, drives the shifter input.
- sh_amount_o  output  SHW  stage-1 register, drives the shifter shift amount.
- sh_list_i  input  SIZE*WIDTH  shifter output, combinational from sh_list_o and sh_amount_o.
- out_valid  output  1  stage-2 result valid.
- out_ready  input  1  downstream accepts the result.
- out_list  output  SIZE*WIDTH  stage-2 register holding the rotated vector.
- out_last  output  1  marks the final vector of the batch; qualified by out_valid.
- done  output  1  one-cycle pulse when the batch completes.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the following, then go to RUN:
    - amt = red(cmd_start)
    - str = red(cmd_stride)
    - rem = cmd_count
  - If cmd_count==0, go straight back to IDLE instead and pulse done on the next cycle. No data is consumed.
- red(x): x ≥ SIZE → x−SIZE, else x. This is a single subtraction, which is exact because 2^SHW−1 < 2*SIZE.
- RUN:
  - in_ready = (rem≠0) && (!s1_valid || adv2).
  - adv2 = !out_valid || out_ready.
  - On the in handshake:
    - sh_list_o←in_list; sh_amount_o←amt; s1_valid←1; s1_last←(rem==1)
    - rem←rem−1
    - amt←(amt+str ≥ SIZE) ? amt+str−SIZE : amt+str
  - The sum amt+str uses SHW+1 bits.
  - When rem reaches 0, go to DRAIN.
- Stage 2:
  - When adv2 && s1_valid: out_list←sh_list_i; out_last←s1_last; out_valid←1.
  - Stage 1 empties unless a new vector loads in the same cycle.
  - When adv2 && !s1_valid: out_valid←0 once the current output is accepted.
- DRAIN:
  - in_ready=0.
  - The out handshake with out_last=1 asserts done for 1 cycle and returns the block to IDLE.
  - A new command can be accepted on the cycle after done.
- Simultaneous events:
  - A stage-1 load and a stage-1 → stage-2 transfer in the same cycle are legal; the pipeline stays full.
  - out_ready may be low indefinitely; the contents of both stages are held stable.
- Shift direction is defined by the shifter: element i moves to (i+amount) mod SIZE.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1.
  - in_ready, out_valid, out_last, done = 0.
  - sh_list_o, sh_amount_o, out_list = 0.
  - amt, str, rem, s1_valid, s1_last = 0.
- Latency: in handshake at cycle t → out_valid at t+2, with out_ready held high.
- Throughput: one vector per cycle when out_ready=1.
- Backpressure: with out_ready low, at most 2 vectors are buffered and in_ready drops.
- out_list, out_last and out_valid are stable while out_valid=1 && out_ready=0.
- done fires in the cycle after the last out handshake, registered.
- Reset asserted mid-batch: all state clears immediately and asynchronously; in-flight vectors are discarded and no done is produced.
- cmd_valid is ignored outside IDLE.

## Test plan
- Basic batch:
  - Stimulus: cmd start=0, stride=1, count=4; vectors with element i = i; out_ready=1.
  - Required: outputs rotated by 0,1,2,3; out_last on the 4th output; done 1 cycle later; first out_valid 2 cycles after the first in handshake.
- Wrap-around:
  - Stimulus: start=250, stride=10, count=3.
  - Required: sh_amount_o sequence 250, 3, 13.
- Operand reduction:
  - Stimulus: start=300, stride=511, count=2.
  - Required: amounts 43, then 43+254=297−257=40.
- Backpressure:
  - Stimulus: count=5; out_ready toggles 1,0,0,1,…
  - Required: no loss or duplication; in_ready=0 while both stages are full; output order and amounts preserved.
- Zero count:
  - Stimulus: count=0.
  - Required: in_ready stays 0; done pulses on the next cycle; cmd_ready high again afterwards.
- Reset mid-batch:
  - Stimulus: drop rst_n after 2 of 6 vectors.
  - Required: out_valid=0 and cmd_ready=1 immediately; a following new batch starts from its own start value.

Source files
------------

// File: rtl/circular_shift_sched_if.sv
// Handshake bundle for the circular shift scheduler:
// command, input vector, shifter loop and result.
interface circular_shift_sched_if #(
  parameter int SIZE  = 257,
  parameter int WIDTH = 32,
  parameter int SHW   = 9
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SHW-1:0]        cmd_start;
  logic [SHW-1:0]        cmd_stride;
  logic [SHW-1:0]        cmd_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [SIZE*WIDTH-1:0] in_list;
  logic [SIZE*WIDTH-1:0] sh_list_o;
  logic [SHW-1:0]        sh_amount_o;
  logic [SIZE*WIDTH-1:0] sh_list_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE*WIDTH-1:0] out_list;
  logic                  out_last;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_start, cmd_stride, cmd_count,
    input  in_valid, in_list, sh_list_i, out_ready,
    output cmd_ready, in_ready, sh_list_o, sh_amount_o,
    output out_valid, out_list, out_last, done
  );

  modport master (
    output cmd_valid, cmd_start, cmd_stride, cmd_count,
    output in_valid, in_list, sh_list_i, out_ready,
    input  cmd_ready, in_ready, sh_list_o, sh_amount_o,
    input  out_valid, out_list, out_last, done
  );
endinterface

// File: rtl/circular_shift_sched.sv
// Batch rotation scheduler: streams vectors through an external
// shifter registered on both sides, amount = start + k*stride mod SIZE.
module circular_shift_sched #(
  parameter int SIZE  = 257,
  parameter int WIDTH = 32,
  parameter int SHW   = 9
) (
  input logic clk,
  input logic rst_n,
  circular_shift_sched_if.slave bus
);
  localparam int LW = SIZE * WIDTH;
  localparam logic [SHW-1:0] SZ  = SIZE[SHW-1:0];
  localparam logic [SHW:0]   SZ1 = SIZE[SHW:0];

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [SHW-1:0] amt_q, amt_d;
  logic [SHW-1:0] str_q, str_d;
  logic [SHW-1:0] rem_q, rem_d;
  logic [SHW-1:0] sh_amount_q, sh_amount_d;
  logic [LW-1:0]  sh_list_q, sh_list_d;
  logic [LW-1:0]  out_list_q, out_list_d;
  logic           s1_valid_q, s1_valid_d;
  logic           s1_last_q, s1_last_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;

  logic           adv2;
  logic           cmd_rdy;
  logic           cmd_hs;
  logic           in_rdy;
  logic           in_hs;
  logic           last_hs;
  logic [SHW:0]   sum;
  logic [SHW:0]   wrap;
  logic [SHW-1:0] amt_nxt;

  // Single subtraction suffices: inputs never reach 2*SIZE.
  function automatic logic [SHW-1:0] red(input logic [SHW-1:0] x);
    red = (x >= SZ) ? x - SZ : x;
  endfunction

  assign adv2    = !out_valid_q || bus.out_ready;
  assign cmd_rdy = (state_q == IDLE) && !done_q;
  assign cmd_hs  = cmd_rdy && bus.cmd_valid;
  assign in_rdy  = (state_q == RUN) && (rem_q != '0)
                && (!s1_valid_q || adv2);
  assign in_hs   = in_rdy && bus.in_valid;
  assign last_hs = out_valid_q && bus.out_ready && out_last_q;

  assign sum     = {1'b0, amt_q} + {1'b0, str_q};
  assign wrap    = sum - SZ1;
  assign amt_nxt = (sum >= SZ1) ? wrap[SHW-1:0] : sum[SHW-1:0];

  always_comb begin
    state_d     = state_q;
    amt_d       = amt_q;
    str_d       = str_q;
    rem_d       = rem_q;
    sh_amount_d = sh_amount_q;
    sh_list_d   = sh_list_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_list_d  = out_list_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_list_d = bus.sh_list_i;
        out_last_d = s1_last_q;
      end else begin
        out_last_d = 1'b0;
      end
    end

    if (in_hs) begin
      sh_list_d   = bus.in_list;
      sh_amount_d = amt_q;
      s1_valid_d  = 1'b1;
      s1_last_d   = (rem_q == SHW'(1));
    end else if (adv2) begin
      s1_valid_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          amt_d = red(bus.cmd_start);
          str_d = red(bus.cmd_stride);
          rem_d = bus.cmd_count;
          if (bus.cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (in_hs) begin
          rem_d = rem_q - SHW'(1);
          amt_d = amt_nxt;
          if (rem_q == SHW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      amt_q       <= '0;
      str_q       <= '0;
      rem_q       <= '0;
      sh_amount_q <= '0;
      sh_list_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_list_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      amt_q       <= amt_d;
      str_q       <= str_d;
      rem_q       <= rem_d;
      sh_amount_q <= sh_amount_d;
      sh_list_q   <= sh_list_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_list_q  <= out_list_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready   = cmd_rdy;
  assign bus.in_ready    = in_rdy;
  assign bus.sh_list_o   = sh_list_q;
  assign bus.sh_amount_o = sh_amount_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_list    = out_list_q;
  assign bus.out_last    = out_last_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_circular_shift_sched.sv
// Randomized bench for circular_shift_sched with a rotation
// reference model and a behavioural combinational shifter.
module tb_circular_shift_sched;
  localparam int SIZE  = 257;
  localparam int WIDTH = 32;
  localparam int SHW   = 9;
  localparam int LW    = SIZE * WIDTH;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cur_start;
  int   cur_stride;
  logic [LW-1:0] vecs [0:15];
  logic [LW-1:0] sh_in;

  circular_shift_sched_if #(
    .SIZE(SIZE), .WIDTH(WIDTH), .SHW(SHW)
  ) bus ();

  circular_shift_sched #(
    .SIZE(SIZE), .WIDTH(WIDTH), .SHW(SHW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shifter: element i moves to (i+amount) mod SIZE.
  always_comb begin
    sh_in = '0;
    for (int i = 0; i < SIZE; i++) begin
      sh_in[((i + int'(bus.sh_amount_o)) % SIZE) * WIDTH +: WIDTH] =
        bus.sh_list_o[i*WIDTH +: WIDTH];
    end
  end
  assign bus.sh_list_i = sh_in;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_amt(input int k);
    return (cur_start + k * cur_stride) % SIZE;
  endfunction

  function automatic logic [LW-1:0] rot(input logic [LW-1:0] v,
                                        input int a);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++)
      r[((i + a) % SIZE) * WIDTH +: WIDTH] = v[i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic int mism(input logic [LW-1:0] a,
                              input logic [LW-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < SIZE; i++)
      if (a[i*WIDTH +: WIDTH] !== b[i*WIDTH +: WIDTH]) n++;
    return n;
  endfunction

  task automatic send_cmd(input int start, input int stride,
                          input int count);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_start  = SHW'(start);
    bus.cmd_stride = SHW'(stride);
    bus.cmd_count  = SHW'(count);
    #1;
    chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    cur_start  = start;
    cur_stride = stride;
  endtask

  // bp: 0 out_ready high, 1 pattern 1,0,0, 2 random with input gaps
  task automatic run_batch(input int start, input int stride,
                           input int count, input int bp,
                           input bit ramp, input int abort_after);
    int  sent, rcvd, t0, cyc;
    bit  first_seen, prev_hs, hs, aborted;
    int  prev_idx;
    sent = 0; rcvd = 0; t0 = -100;
    first_seen = 0; prev_hs = 0; aborted = 0; prev_idx = 0;
    for (int k = 0; k < count; k++)
      for (int i = 0; i < SIZE; i++)
        vecs[k][i*WIDTH +: WIDTH] = ramp ? WIDTH'(i) : $urandom;
    send_cmd(start, stride, count);
    if (count == 0) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      chk("zero_done", bus.done, 1);
      chk("zero_in_ready", bus.in_ready, 0);
      @(negedge clk);
      #1;
      chk("zero_done_off", bus.done, 0);
      chk("zero_cmd_ready", bus.cmd_ready, 1);
      chk("zero_in_ready2", bus.in_ready, 0);
      return;
    end
    for (cyc = 0; cyc < 300 && rcvd < count; cyc++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (prev_hs)
        chk("sh_amount", bus.sh_amount_o, exp_amt(prev_idx));
      bus.in_valid = (sent < count)
                  && (bp != 2 || $urandom_range(0, 3) != 0);
      if (sent < count) bus.in_list = vecs[sent];
      unique case (bp)
        1:       bus.out_ready = (cyc % 3 == 0);
        2:       bus.out_ready = $urandom_range(0, 1) == 1;
        default: bus.out_ready = 1'b1;
      endcase
      #1;
      chk("in_ready", bus.in_ready,
          (sent < count) && ((sent - rcvd) < 2 || bus.out_ready));
      chk("done_busy", bus.done, 0);
      if (!first_seen && bus.out_valid) begin
        chk("latency", cyc - t0, 2);
        first_seen = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_data",
            mism(bus.out_list, rot(vecs[rcvd], exp_amt(rcvd))), 0);
        chk("out_last", bus.out_last, rcvd == count - 1);
        rcvd++;
      end
      hs = bus.in_valid && bus.in_ready;
      if (hs) begin
        if (sent == 0) t0 = cyc;
        prev_idx = sent;
        sent++;
      end
      prev_hs = hs;
      @(posedge clk);
      if (abort_after > 0 && sent == abort_after) begin
        aborted = 1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_sh_amount", bus.sh_amount_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_no_done", bus.done, 0);
      return;
    end
    chk("batch_complete", rcvd, count);
    @(negedge clk);
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_out_valid", bus.out_valid, 0);
    @(negedge clk);
    #1;
    chk("done_off", bus.done, 0);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cur_start = 0;
    cur_stride = 0;
    rst_n = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_start  = '0;
    bus.cmd_stride = '0;
    bus.cmd_count  = '0;
    bus.in_valid   = 1'b0;
    bus.in_list    = '0;
    bus.out_ready  = 1'b0;
    #23;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_last", bus.out_last, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_sh_amount", bus.sh_amount_o, 0);
    chk("reset_out_list", longint'(|bus.out_list), 0);
    chk("reset_sh_list", longint'(|bus.sh_list_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_batch(0, 1, 4, 0, 1, 0);
    run_batch(250, 10, 3, 0, 0, 0);
    run_batch(300, 511, 2, 0, 0, 0);
    run_batch(100, 77, 5, 1, 0, 0);
    run_batch(5, 6, 0, 0, 0, 0);
    run_batch(5, 9, 6, 1, 0, 2);
    run_batch(7, 3, 3, 0, 0, 0);
    for (int b = 0; b < 6; b++)
      run_batch($urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(1, 12), 2, 0, 0);
    run_batch(256, 256, 8, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
